rect_plotter: RTL and testbench

- Parametrised rectangle rasteriser for the VGA path; successor to the fixed-geometry dash/graph/part/clear drawers.
- Accepts one rectangle command and streams (x, y, colour) pixels to the VGA adaptor under valid/ready handshake.
- Supports filled and outline modes and clips pixels outside the screen.
- Game datapath issues one command per primitive: gallows beam, body segment, dash, or full-screen clear.

---
 rtl/rect_plotter.sv | 177 +++++++++++++++++
 tb/tb_rect_plotter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_plotter.sv
// Rectangle rasteriser: takes one rectangle command and streams its pixels
// (x, y, colour) to the VGA adaptor under a plot/ready handshake. Filled or
// outline mode. Pixels that fall off the visible screen are skipped without
// waiting for ready.
module rect_plotter #(
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned C_W      = 3,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  input  logic [C_W-1:0] colour_in,
  input  logic           outline,
  input  logic           ready,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [C_W-1:0] colour,
  output logic           plot,
  output logic           busy,
  output logic           done
);

  localparam logic [X_W:0] XLim = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] YLim = (Y_W+1)'(SCREEN_H);

  typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;

  state_e state_q, state_d;

  logic [X_W-1:0] x0_q, x0_d, w_q, w_d, col_q, col_d, col_nxt;
  logic [Y_W-1:0] y0_q, y0_d, h_q, h_d, row_q, row_d, row_nxt;
  logic           outline_q, outline_d;
  logic [X_W-1:0] x_d;
  logic [Y_W-1:0] y_d;
  logic [C_W-1:0] colour_d;
  logic           plot_d;
  logic [X_W:0]   sum_x;
  logic [Y_W:0]   sum_y;
  logic           last_col, last_row, edge_row, last_pix, advance;

  // In DRAW the registered plot flag doubles as "current pixel is visible",
  // so a clipped pixel (plot=0) always advances.
  assign last_col = (col_q == w_q - X_W'(1));
  assign last_row = (row_q == h_q - Y_W'(1));
  assign edge_row = (row_q == '0) || last_row;
  assign last_pix = last_col && last_row;
  assign advance  = ~plot | ready;

  // Next scan position; outline interior rows jump from col 0 to col w-1.
  always_comb begin
    col_nxt = col_q + X_W'(1);
    row_nxt = row_q;
    if (last_col) begin
      col_nxt = '0;
      row_nxt = row_q + Y_W'(1);
    end else if (outline_q && !edge_row && (col_q == '0)) begin
      col_nxt = w_q - X_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = ((w == '0) || (h == '0)) ? StDone : StDraw;
      StDraw: if (advance && last_pix) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM-decoded status outputs.
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  // Datapath next values: command latch, scan counters and pixel outputs.
  always_comb begin
    x0_d      = x0_q;
    y0_d      = y0_q;
    w_d       = w_q;
    h_d       = h_q;
    outline_d = outline_q;
    col_d     = col_q;
    row_d     = row_q;
    x_d       = x;
    y_d       = y;
    colour_d  = colour;
    plot_d    = plot;
    sum_x     = '0;
    sum_y     = '0;
    unique case (state_q)
      StIdle: begin
        plot_d = 1'b0;
        if (start) begin
          x0_d      = x0;
          y0_d      = y0;
          w_d       = w;
          h_d       = h;
          outline_d = outline;
          colour_d  = colour_in;
          col_d     = '0;
          row_d     = '0;
          if ((w != '0) && (h != '0)) begin
            sum_x  = {1'b0, x0};
            sum_y  = {1'b0, y0};
            x_d    = x0;
            y_d    = y0;
            plot_d = ~((sum_x >= XLim) | (sum_y >= YLim));
          end
        end
      end
      StDraw: begin
        if (advance) begin
          if (last_pix) begin
            plot_d = 1'b0;
          end else begin
            col_d  = col_nxt;
            row_d  = row_nxt;
            // One bit wider so coordinates past the register range still clip.
            sum_x  = {1'b0, x0_q} + {1'b0, col_nxt};
            sum_y  = {1'b0, y0_q} + {1'b0, row_nxt};
            x_d    = sum_x[X_W-1:0];
            y_d    = sum_y[Y_W-1:0];
            plot_d = ~((sum_x >= XLim) | (sum_y >= YLim));
          end
        end
      end
      StDone: plot_d = 1'b0;
      default: plot_d = 1'b0;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      outline_q <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      x         <= '0;
      y         <= '0;
      colour    <= '0;
      plot      <= 1'b0;
    end else begin
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      w_q       <= w_d;
      h_q       <= h_d;
      outline_q <= outline_d;
      col_q     <= col_d;
      row_q     <= row_d;
      x         <= x_d;
      y         <= y_d;
      colour    <= colour_d;
      plot      <= plot_d;
    end
  end

endmodule

// File: tb/tb_rect_plotter.sv
// Randomised self-checking bench for rect_plotter. Expected pixels come from a
// set-membership model of the rectangle; cycle counts from the handshake rule.
module tb_rect_plotter;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [7:0] w;
  logic [6:0] h;
  logic [2:0] colour_in;
  logic       outline;
  logic       ready;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  rect_plotter dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .w         (w),
    .h         (h),
    .colour_in (colour_in),
    .outline   (outline),
    .ready     (ready),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model output and observations of the last command.
  int exp_q[$];
  int obs_q[$];
  int n_incl;
  int done_cyc, stalls, busy_bad, col_bad, hold_bad;
  logic c0_busy, c0_done;

  // Pixels of the rectangle in scan order: a pixel belongs to the command if
  // the rectangle is filled or it lies on the border; it is plotted if on screen.
  function automatic void build_exp(int cx, int cy, int cw, int ch, bit ol);
    exp_q.delete();
    n_incl = 0;
    for (int r = 0; r < ch; r++)
      for (int c = 0; c < cw; c++)
        if (!ol || r == 0 || r == ch - 1 || c == 0 || c == cw - 1) begin
          n_incl++;
          if (cx + c < 160 && cy + r < 120) exp_q.push_back((cx + c) * 256 + (cy + r));
        end
  endfunction

  // Index of first difference between observed and expected pixels, -1 if equal.
  function automatic int first_diff();
    int n;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (obs_q[i] != exp_q[i]) return i;
    if (obs_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  // Issue one command and record what the DUT does until done (bounded).
  // rmode: 0 ready high, 1 random ready, 2 ready low in cycles 1-2.
  task automatic run_cmd(input int cx, input int cy, input int cw, input int ch, input int cc,
                         input bit ol, input int rmode, input bit poke_start);
    int  cyc;
    bit  stall_prev;
    logic [7:0] px;
    logic [6:0] py;
    obs_q.delete();
    done_cyc = -1; stalls = 0; busy_bad = 0; col_bad = 0; hold_bad = 0;
    @(posedge clk); #1;
    start = 1'b1; x0 = cx[7:0]; y0 = cy[6:0]; w = cw[7:0]; h = ch[6:0];
    colour_in = cc[2:0]; outline = ol; ready = 1'b1;
    @(negedge clk);
    c0_busy = busy; c0_done = done;
    cyc = 0; stall_prev = 1'b0; px = '0; py = '0;
    while (cyc < 25000) begin
      @(posedge clk); #1;
      cyc++;
      start = poke_start && (cyc == 3);
      x0 = 8'($urandom); y0 = 7'($urandom); w = 8'($urandom); h = 7'($urandom);
      colour_in = 3'($urandom); outline = 1'($urandom);
      ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : (cyc > 2);
      @(negedge clk);
      if (stall_prev && !(plot && x == px && y == py)) hold_bad++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (!busy) busy_bad++;
      if (plot && colour != cc[2:0]) col_bad++;
      if (plot && ready) obs_q.push_back(int'(x) * 256 + int'(y));
      stall_prev = plot && !ready;
      if (stall_prev) stalls++;
      px = x; py = y;
    end
    start = 1'b0;
    ready = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; ready = 1'b1; x0 = 8'd77; y0 = 7'd33; w = 8'd5; h = 7'd5;
    colour_in = 3'd7; outline = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({x, y, colour, plot, busy, done} !== '0) begin
      n_errors++;
      $display("FAIL reset_hold: got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b, want all 0",
               x, y, colour, plot, busy, done);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({x, y, colour, plot, busy, done} !== '0) begin
      n_errors++;
      $display("FAIL reset_idle: got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b, want all 0",
               x, y, colour, plot, busy, done);
    end
  endtask

  task automatic test_filled();
    build_exp(10, 20, 3, 2, 1'b0);
    run_cmd(10, 20, 3, 2, 2, 1'b0, 0, 1'b0);
    n_checks++;
    if (first_diff() != -1) begin
      n_errors++;
      $display("FAIL filled_pixels: got %0d pixels, diff at %0d, want %0d pixels",
               obs_q.size(), first_diff(), exp_q.size());
    end
    n_checks++;
    if (done_cyc != 7 || busy_bad != 0 || col_bad != 0) begin
      n_errors++;
      $display("FAIL filled_timing: got done=%0d busy_bad=%0d col_bad=%0d, want done=7 0 0",
               done_cyc, busy_bad, col_bad);
    end
  endtask

  task automatic test_outline();
    build_exp(10, 20, 4, 3, 1'b1);
    run_cmd(10, 20, 4, 3, 5, 1'b1, 0, 1'b0);
    n_checks++;
    if (first_diff() != -1 || obs_q.size() != 10) begin
      n_errors++;
      $display("FAIL outline_pixels: got %0d pixels diff at %0d, want 10", obs_q.size(),
               first_diff());
    end
    n_checks++;
    if (done_cyc != 11) begin
      n_errors++;
      $display("FAIL outline_done: got cycle %0d, want 11", done_cyc);
    end
  endtask

  task automatic test_backpressure();
    build_exp(0, 0, 2, 1, 1'b0);
    run_cmd(0, 0, 2, 1, 1, 1'b0, 2, 1'b0);
    n_checks++;
    if (first_diff() != -1 || hold_bad != 0 || stalls != 2) begin
      n_errors++;
      $display("FAIL backpressure: got diff=%0d hold_bad=%0d stalls=%0d, want -1 0 2",
               first_diff(), hold_bad, stalls);
    end
    n_checks++;
    if (done_cyc != 5) begin
      n_errors++;
      $display("FAIL backpressure_done: got cycle %0d, want 5", done_cyc);
    end
  endtask

  task automatic test_clip();
    build_exp(158, 119, 4, 2, 1'b0);
    run_cmd(158, 119, 4, 2, 6, 1'b0, 0, 1'b0);
    n_checks++;
    if (first_diff() != -1 || obs_q.size() != 2 || done_cyc != 9) begin
      n_errors++;
      $display("FAIL clip_ready: got %0d pixels diff=%0d done=%0d, want 2 -1 9",
               obs_q.size(), first_diff(), done_cyc);
    end
    run_cmd(158, 119, 4, 2, 6, 1'b1, 1, 1'b0);
    n_checks++;
    if (first_diff() != -1 || done_cyc != n_incl + stalls + 1 || hold_bad != 0) begin
      n_errors++;
      $display("FAIL clip_random: got diff=%0d done=%0d hold_bad=%0d, want -1 %0d 0",
               first_diff(), done_cyc, hold_bad, n_incl + stalls + 1);
    end
  endtask

  task automatic test_zero_size();
    run_cmd(30, 30, 0, 4, 3, 1'b0, 0, 1'b0);
    n_checks++;
    if (done_cyc != 1 || obs_q.size() != 0) begin
      n_errors++;
      $display("FAIL zero_w: got done=%0d plots=%0d, want 1 0", done_cyc, obs_q.size());
    end
    run_cmd(30, 30, 4, 0, 3, 1'b1, 0, 1'b0);
    n_checks++;
    if (done_cyc != 1 || obs_q.size() != 0) begin
      n_errors++;
      $display("FAIL zero_h: got done=%0d plots=%0d, want 1 0", done_cyc, obs_q.size());
    end
  endtask

  task automatic test_start_ignored();
    build_exp(50, 60, 3, 3, 1'b0);
    run_cmd(50, 60, 3, 3, 4, 1'b0, 0, 1'b1);
    n_checks++;
    if (first_diff() != -1 || obs_q.size() != 9 || done_cyc != 10 || col_bad != 0) begin
      n_errors++;
      $display("FAIL start_ignored: got plots=%0d diff=%0d done=%0d col_bad=%0d, want 9 -1 10 0",
               obs_q.size(), first_diff(), done_cyc, col_bad);
    end
  endtask

  task automatic test_back_to_back();
    build_exp(5, 6, 2, 2, 1'b0);
    run_cmd(5, 6, 2, 2, 1, 1'b0, 0, 1'b0);
    build_exp(7, 8, 3, 1, 1'b1);
    run_cmd(7, 8, 3, 1, 2, 1'b1, 0, 1'b0);
    n_checks++;
    if (c0_done !== 1'b0 || c0_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL done_pulse_len: got done=%b busy=%b after done, want 0 0", c0_done, c0_busy);
    end
    n_checks++;
    if (first_diff() != -1 || done_cyc != 4) begin
      n_errors++;
      $display("FAIL back_to_back: got diff=%0d done=%0d, want -1 4", first_diff(), done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    @(posedge clk); #1;
    start = 1'b1; x0 = 8'd10; y0 = 7'd20; w = 8'd5; h = 7'd5; colour_in = 3'd7;
    outline = 1'b0; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (!(plot && x == 8'd13 && y == 7'd20)) begin
      n_errors++;
      $display("FAIL mid_pixel3: got plot=%b (%0d,%0d), want 1 (13,20)", plot, x, y);
    end
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({x, y, colour, plot, busy, done} !== '0) begin
      n_errors++;
      $display("FAIL mid_reset_async: got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b, want 0",
               x, y, colour, plot, busy, done);
    end
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) bad++;
    end
    resetn = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done || busy || plot) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL mid_no_done: got %0d cycles with done/busy/plot, want 0", bad);
    end
    build_exp(40, 50, 2, 2, 1'b0);
    run_cmd(40, 50, 2, 2, 3, 1'b0, 0, 1'b0);
    n_checks++;
    if (first_diff() != -1 || done_cyc != 5) begin
      n_errors++;
      $display("FAIL mid_restart: got diff=%0d done=%0d, want -1 5", first_diff(), done_cyc);
    end
  endtask

  task automatic test_clear();
    run_cmd(0, 0, 160, 120, 0, 1'b0, 0, 1'b0);
    n_checks++;
    if (obs_q.size() != 19200 || done_cyc != 19201) begin
      n_errors++;
      $display("FAIL clear_screen: got plots=%0d done=%0d, want 19200 19201", obs_q.size(),
               done_cyc);
    end
  endtask

  task automatic test_random();
    int cx, cy, cw, ch, cc;
    bit ol;
    for (int i = 0; i < 60; i++) begin
      cx = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 255) : $urandom_range(0, 159);
      cy = ($urandom_range(0, 3) == 0) ? $urandom_range(112, 127) : $urandom_range(0, 119);
      cw = $urandom_range(0, 12);
      ch = $urandom_range(0, 9);
      cc = $urandom_range(0, 7);
      ol = 1'($urandom_range(0, 1));
      build_exp(cx, cy, cw, ch, ol);
      run_cmd(cx, cy, cw, ch, cc, ol, 1, 1'($urandom_range(0, 1)));
      n_checks++;
      if (first_diff() != -1) begin
        n_errors++;
        $display("FAIL rand_pixels[%0d]: (%0d,%0d) %0dx%0d ol=%b got %0d pixels diff at %0d, want %0d",
                 i, cx, cy, cw, ch, ol, obs_q.size(), first_diff(), exp_q.size());
      end
      n_checks++;
      if (done_cyc != n_incl + stalls + 1 || busy_bad != 0 || col_bad != 0 || hold_bad != 0) begin
        n_errors++;
        $display("FAIL rand_timing[%0d]: got done=%0d busy_bad=%0d col_bad=%0d hold_bad=%0d, want done=%0d 0 0 0",
                 i, done_cyc, busy_bad, col_bad, hold_bad, n_incl + stalls + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_filled();
    test_outline();
    test_backpressure();
    test_clip();
    test_zero_size();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
